ldpc_codeword_packer: RTL and testbench



---
 rtl/ldpc_codeword_packer.sv | 212 +++++++++++++++++++++
 tb/tb_ldpc_codeword_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_codeword_packer.sv
// Captures one LDPC codeword burst and repacks its valid bits LSB-first onto a valid/ready word stream.
// Optional LDPC_PACKER_STATS_EN adds frame_cnt/drop_cnt outputs.
module ldpc_codeword_packer #(
  parameter int MAX_BLOCK_SIZE = 64,
  parameter int MAX_COLS       = 32,
  parameter int OUT_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enc_done,
  input  logic [MAX_BLOCK_SIZE-1:0]           enc_data,
  input  logic [$clog2(MAX_COLS+1)-1:0]       cols_cfg,
  input  logic [$clog2(MAX_BLOCK_SIZE)-1:0]   block_size_cfg,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic                                frame_err
`ifdef LDPC_PACKER_STATS_EN
  ,
  output logic [15:0]                         frame_cnt,
  output logic [15:0]                         drop_cnt
`endif
);

  localparam int CW    = $clog2(MAX_COLS + 1);
  localparam int BSW   = $clog2(MAX_BLOCK_SIZE);
  localparam int BV    = BSW + 1;
  localparam int IW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int ACC_W = OUT_WIDTH + MAX_BLOCK_SIZE;
  localparam int FW    = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  // Stream handshake: a word moves when out_valid & out_ready; while stalled the
  // word and its last flag hold, and out_valid only falls after a transfer.
  state_t                     state_q;
  logic [IW-1:0]              beat_q;
  logic [CW-1:0]              blk_q;
  logic [CW-1:0]              cols_q;
  logic [BV-1:0]              bs_q;
  logic [ACC_W-1:0]           acc_q;
  logic [FW-1:0]              fill_q;
  logic                       skip_q;
  logic                       out_valid_q;
  logic                       out_last_q;
  logic [OUT_WIDTH-1:0]       out_data_q;
  logic                       busy_q;
  logic                       frame_err_q;
  logic [MAX_BLOCK_SIZE-1:0]  buf_q [MAX_COLS];
`ifdef LDPC_PACKER_STATS_EN
  logic [15:0]                frame_cnt_q;
  logic [15:0]                drop_cnt_q;
`endif

  logic [CW-1:0]              cfg_cols, eff_cols, blk_v, blk_n;
  logic [BV-1:0]              cfg_bs, eff_bs;
  logic                       start, cap_beat, append, drop_start;
  logic                       slot_free, all_app, load, load_last;
  logic [IW-1:0]              wr_idx;
  logic [MAX_BLOCK_SIZE-1:0]  blk_src, masked;
  logic [ACC_W-1:0]           acc_v, acc_n;
  logic [FW-1:0]              fill_v, fill_n;

  always_comb begin
    cfg_cols   = (cols_cfg == '0) ? CW'(MAX_COLS) : cols_cfg;
    cfg_bs     = (block_size_cfg == '0) ? BV'(MAX_BLOCK_SIZE) : {1'b0, block_size_cfg};
    eff_cols   = (state_q == S_IDLE) ? cfg_cols : cols_q;
    eff_bs     = (state_q == S_IDLE) ? cfg_bs : bs_q;
    start      = (state_q == S_IDLE) && enc_done && !skip_q;
    cap_beat   = start || ((state_q == S_CAPTURE) && enc_done);
    drop_start = (state_q == S_DRAIN) && enc_done && !skip_q;
    wr_idx     = start ? '0 : beat_q;

    // Blocks are appended straight from enc_data during capture so the first
    // word is ready as soon as the burst ends; the rest come from the buffer.
    blk_src = (state_q == S_DRAIN) ? buf_q[IW'(blk_q)] : enc_data;
    masked  = blk_src & ~({MAX_BLOCK_SIZE{1'b1}} << eff_bs);
    append  = ((state_q == S_DRAIN) || cap_beat) && (blk_q < eff_cols) &&
              (fill_q < FW'(OUT_WIDTH));

    acc_v  = acc_q;
    fill_v = fill_q;
    blk_v  = blk_q + CW'(1);
    blk_n  = blk_q;
    if (append) begin
      acc_v  = acc_q | (ACC_W'(masked) << fill_q);
      fill_v = fill_q + FW'(eff_bs);
      blk_n  = blk_v;
    end
    all_app   = (blk_n == eff_cols);
    slot_free = !out_valid_q || out_ready;
    load      = (state_q == S_DRAIN) && slot_free && !(out_valid_q && out_last_q) &&
                ((fill_v >= FW'(OUT_WIDTH)) || (all_app && (fill_v != '0)));
    load_last = all_app && (fill_v <= FW'(OUT_WIDTH));
    acc_n     = load ? (acc_v >> OUT_WIDTH) : acc_v;
    fill_n    = fill_v;
    if (load) fill_n = (fill_v > FW'(OUT_WIDTH)) ? (fill_v - FW'(OUT_WIDTH)) : '0;
  end

  always_ff @(posedge clk) begin
    if (cap_beat) buf_q[wr_idx] <= enc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      blk_q       <= '0;
      cols_q      <= '0;
      bs_q        <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef LDPC_PACKER_STATS_EN
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
`endif
    end else begin
      // A burst that starts while draining is ignored until enc_done falls.
      if (!enc_done)       skip_q <= 1'b0;
      else if (drop_start) skip_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            cols_q      <= cfg_cols;
            bs_q        <= cfg_bs;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b1;
            acc_q       <= acc_n;
            fill_q      <= fill_n;
            blk_q       <= blk_n;
            beat_q      <= IW'(1);
            state_q     <= (MAX_COLS == 1) ? S_DRAIN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (enc_done) begin
            acc_q  <= acc_n;
            fill_q <= fill_n;
            blk_q  <= blk_n;
            if (beat_q == IW'(MAX_COLS - 1)) begin
              beat_q  <= '0;
              state_q <= S_DRAIN;
            end else begin
              beat_q <= beat_q + IW'(1);
            end
          end else begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            fill_q      <= '0;
            blk_q       <= '0;
            beat_q      <= '0;
            state_q     <= S_IDLE;
`ifdef LDPC_PACKER_STATS_EN
            drop_cnt_q  <= drop_cnt_q + 16'd1;
`endif
          end
        end
        S_DRAIN: begin
          acc_q  <= acc_n;
          fill_q <= fill_n;
          blk_q  <= blk_n;
          if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_v[OUT_WIDTH-1:0];
            out_last_q  <= load_last;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              out_last_q <= 1'b0;
              busy_q     <= 1'b0;
              acc_q      <= '0;
              fill_q     <= '0;
              blk_q      <= '0;
              state_q    <= S_IDLE;
`ifdef LDPC_PACKER_STATS_EN
              frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
            end
          end
          if (drop_start) begin
            frame_err_q <= 1'b1;
`ifdef LDPC_PACKER_STATS_EN
            drop_cnt_q  <= drop_cnt_q + 16'd1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef LDPC_PACKER_STATS_EN
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ldpc_codeword_packer.sv
// Bench for ldpc_codeword_packer: table vectors, corner sequences and randomized codewords
// checked against a bit-queue reference model (MAX_BLOCK_SIZE=8, MAX_COLS=4, OUT_WIDTH=16).
module tb_ldpc_codeword_packer;
  localparam int MBS = 8;
  localparam int MC  = 4;
  localparam int OW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_done;
  logic [MBS-1:0] enc_data;
  logic [2:0]    cols_cfg;
  logic [2:0]    block_size_cfg;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          frame_err;
`ifdef LDPC_PACKER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;
`endif

  ldpc_codeword_packer #(.MAX_BLOCK_SIZE(MBS), .MAX_COLS(MC), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .enc_done(enc_done), .enc_data(enc_data),
    .cols_cfg(cols_cfg), .block_size_cfg(block_size_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_err(frame_err)
`ifdef LDPC_PACKER_STATS_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] blocks;
    int          cols;
    int          bs;
    int          nwords;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;
  vec_t vecs [7];

  logic [OW:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / protocol monitor, sampled on the falling edge
  logic pv, pr, pl;
  logic [OW-1:0] pd;
  logic [OW:0] e_m;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected no word", out_data, out_last);
        end else begin
          e_m = exp_q.pop_front();
          check("word_data", out_data, e_m[OW-1:0]);
          check("word_last", out_last, e_m[OW]);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input logic [31:0] blocks, input int cols, input int bs, input int beats);
    for (int i = 0; i < beats; i++) begin
      enc_done       = 1'b1;
      enc_data       = blocks[i*8 +: 8];
      cols_cfg       = (cols == MC && $urandom_range(0, 1) == 1) ? 3'd0 : 3'(cols);
      block_size_cfg = (bs == MBS) ? 3'd0 : 3'(bs);
      tick();
    end
    enc_done       = 1'b0;
    enc_data       = MBS'($urandom);
    cols_cfg       = 3'($urandom);
    block_size_cfg = 3'($urandom);
  endtask

  // reference model: flatten valid bits into a queue, cut into zero-padded words
  task automatic model_push(input logic [31:0] blocks, input int cols, input int bs);
    bit bits [$];
    logic [OW-1:0] w;
    for (int c = 0; c < cols; c++)
      for (int b = 0; b < bs; b++)
        bits.push_back(blocks[c*8 + b]);
    while (bits.size() > 0) begin
      w = '0;
      for (int i = 0; i < OW && bits.size() > 0; i++) w[i] = bits.pop_front();
      exp_q.push_back({(bits.size() == 0), w});
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_q.push_back({(v.nwords == 1), v.w0});
    if (v.nwords == 2) exp_q.push_back({1'b1, v.w1});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (k < budget && (busy || out_valid || exp_q.size() != 0)) begin
      tick();
      k++;
    end
    check(name, {busy, out_valid, (exp_q.size() == 0)}, 3'b001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LDPC_PACKER_STATS_EN
    logic [15:0] f0, d0;
`endif
    logic [31:0] rb;
    int rc, rs;
    vecs[0] = '{32'h01FF3CA5, 4, 8, 2, 16'h3CA5, 16'h01FF};
    vecs[1] = '{32'hEE15001F, 3, 5, 1, 16'h541F, 16'h0000};
    vecs[2] = '{32'h0000005A, 1, 8, 1, 16'h005A, 16'h0000};
    vecs[3] = '{32'h78563412, 4, 4, 1, 16'h8642, 16'h0000};
    vecs[4] = '{32'hFFFFFFFF, 4, 7, 2, 16'hFFFF, 16'h0FFF};
    vecs[5] = '{32'h00000103, 2, 1, 1, 16'h0003, 16'h0000};
    vecs[6] = '{32'h002A003F, 3, 6, 2, 16'hA03F, 16'h0002};

    rst = 1'b1; enc_done = 1'b0; enc_data = '0; cols_cfg = '0; block_size_cfg = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_data", out_data, 0);
`ifdef LDPC_PACKER_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // table vectors
    for (int v = 0; v < 7; v++) begin
      push_vec(vecs[v]);
      send_burst(vecs[v].blocks, vecs[v].cols, vecs[v].bs, MC);
      tick();
      check("latency_valid", out_valid, 1);
      wait_idle("vec_done", 40);
      check("vec_ferr", frame_err, 0);
    end

    // backpressure on the first word
    out_ready = 1'b0;
    push_vec(vecs[0]);
    send_burst(vecs[0].blocks, 4, 8, MC);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 16'h3CA5);
      check("bp_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("bp_done", 40);

    // truncated burst, then recovery
`ifdef LDPC_PACKER_STATS_EN
    d0 = drop_cnt;
`endif
    send_burst(vecs[0].blocks, 4, 8, 2);
    for (int i = 0; i < 6; i++) begin
      check("trunc_no_valid", out_valid, 0);
      tick();
    end
    check("trunc_ferr", frame_err, 1);
    check("trunc_busy", busy, 0);
`ifdef LDPC_PACKER_STATS_EN
    check("trunc_drop_cnt", drop_cnt, d0 + 16'd1);
`endif
    push_vec(vecs[0]);
    send_burst(vecs[0].blocks, 4, 8, MC);
    wait_idle("trunc_recover", 40);
    check("trunc_ferr_clear", frame_err, 0);

    // overrun: a second burst arrives back-to-back while draining
`ifdef LDPC_PACKER_STATS_EN
    f0 = frame_cnt;
    d0 = drop_cnt;
`endif
    push_vec(vecs[0]);
    send_burst(vecs[0].blocks, 4, 8, MC);
    send_burst(32'hDEADBEEF, 4, 8, MC);
    wait_idle("ovr_done", 40);
    repeat (8) tick();
    check("ovr_ferr", frame_err, 1);
    check("ovr_busy", busy, 0);
`ifdef LDPC_PACKER_STATS_EN
    check("ovr_frame_cnt", frame_cnt, f0 + 16'd1);
    check("ovr_drop_cnt", drop_cnt, d0 + 16'd1);
`endif

    // reset in the middle of draining, after the first word
    push_vec(vecs[0]);
    send_burst(vecs[0].blocks, 4, 8, MC);
    begin
      int k = 0;
      while (k < 10 && exp_q.size() != 1) begin
        tick();
        k++;
      end
      check("mid_word0_sent", exp_q.size(), 1);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ferr", frame_err, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    push_vec(vecs[1]);
    send_burst(vecs[1].blocks, 3, 5, MC);
    wait_idle("post_rst_done", 40);
    repeat (4) tick();
    check("post_rst_idle", {busy, out_valid}, 2'b00);

    // randomized codewords with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rb = $urandom;
      rc = $urandom_range(1, MC);
      rs = $urandom_range(1, MBS);
      model_push(rb, rc, rs);
      send_burst(rb, rc, rs, MC);
      wait_idle("rand_done", 80);
      check("rand_ferr", frame_err, 0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
